// File: rtl/uart_mem_cmd_pkg.sv
// Shared definitions for the UART memory command sequencer.
//  - Command opcodes received over the UART RX path.
//  - FSM state encoding.
//  - reg_sel(): maps a register opcode onto the read-back/write select
//    (0 = access count, 1..4 = address byte 0..3, LSB first).
package uart_mem_cmd_pkg;

  localparam logic [7:0] CMD_WR_MEM_ACCESS_COUNT = 8'hA0;
  localparam logic [7:0] CMD_RD_MEM_ACCESS_COUNT = 8'hA1;
  localparam logic [7:0] CMD_WR_MEM_ADDR0        = 8'hB0;
  localparam logic [7:0] CMD_WR_MEM_ADDR1        = 8'hB1;
  localparam logic [7:0] CMD_WR_MEM_ADDR2        = 8'hB2;
  localparam logic [7:0] CMD_WR_MEM_ADDR3        = 8'hB3;
  localparam logic [7:0] CMD_RD_MEM_ADDR0        = 8'hC0;
  localparam logic [7:0] CMD_RD_MEM_ADDR1        = 8'hC1;
  localparam logic [7:0] CMD_RD_MEM_ADDR2        = 8'hC2;
  localparam logic [7:0] CMD_RD_MEM_ADDR3        = 8'hC3;
  localparam logic [7:0] CMD_DO_MEM_WRITE        = 8'hD0;
  localparam logic [7:0] CMD_DO_MEM_READ         = 8'hD1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ARG,
    S_SEND_RSP,
    S_WR_DATA,
    S_WR_MEM,
    S_RD_MEM,
    S_RD_SEND
  } state_t;

  localparam logic [2:0] SEL_COUNT = 3'd0;

  // Ax selects the count register; Bk/Ck select address byte k.
  function automatic logic [2:0] reg_sel(input logic [7:0] op);
    if (op[7:4] == 4'hA) return SEL_COUNT;
    return {1'b0, op[1:0]} + 3'd1;
  endfunction

endpackage

// File: rtl/uart_mem_cmd_regs.sv
// Access-count and access-address registers with a byte write port and a
// byte-wide read-back mux.
// Ports:
//  clk, resetn  clock, synchronous active-low reset
//  wr_en        write wdata into the register byte chosen by sel
//  sel          0 = count, 1..4 = address byte 0..3
//  wdata        byte to write
//  count, addr  full register values
//  rd_byte      register byte chosen by sel (combinational)
module uart_mem_cmd_regs
  import uart_mem_cmd_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [2:0]        sel,
  input  logic [7:0]        wdata,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        rd_byte
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
      addr  <= '0;
    end else if (wr_en) begin
      if (sel == SEL_COUNT) count <= CNT_W'(wdata);
      for (int k = 0; k < 4; k++)
        if (sel == 3'(k + 1)) addr[8*k +: 8] <= wdata;
    end
  end

  always_comb begin
    rd_byte = 8'(count);
    for (int k = 0; k < 4; k++)
      if (sel == 3'(k + 1)) rd_byte = addr[8*k +: 8];
  end

endmodule

// File: rtl/uart_mem_cmd_ctrl.sv
// Command sequencer between the UART RX/TX pair and a byte-wide memory port.
// Decodes command bytes, owns the count/address registers, returns register
// read-backs over TX and runs memory write/read bursts.
// Ports:
//  clk, resetn            clock, synchronous active-low reset
//  rx_valid, rx_data      received byte strobe + data
//  tx_en, tx_data, tx_busy transmit strobe, byte, transmitter busy
//  mem_req/we/addr/wdata  memory request (held until mem_gnt)
//  mem_gnt, mem_rdata     request accepted; read data valid with the grant
//  busy                   FSM not idle
//  err                    pulse: unknown opcode, dropped byte or grant timeout
module uart_mem_cmd_ctrl
  import uart_mem_cmd_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t            state;
  logic [2:0]        tgt;      // register targeted by the current Ax/Bx/Cx command
  logic [ADDR_W-1:0] ptr;      // burst address; the addr register itself is untouched
  logic [CNT_W-1:0]  rem;      // bytes left in the burst
  logic [7:0]        rdata_q;
  logic [TMO_W-1:0]  tmo_cnt;

  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rd_byte;
  logic              reg_we;
  logic              last;

  assign reg_we   = (state == S_GET_ARG) && rx_valid;
  assign last     = (rem == CNT_W'(1));
  assign mem_addr = ptr;
  assign busy     = (state != S_IDLE);

  uart_mem_cmd_regs #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_regs (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (reg_we),
    .sel     (tgt),
    .wdata   (rx_data),
    .count   (count),
    .addr    (addr),
    .rd_byte (rd_byte)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      tgt       <= SEL_COUNT;
      ptr       <= '0;
      rem       <= '0;
      rdata_q   <= '0;
      tmo_cnt   <= '0;
      tx_en     <= 1'b0;
      tx_data   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: if (rx_valid) begin
          case (rx_data)
            CMD_WR_MEM_ACCESS_COUNT, CMD_WR_MEM_ADDR0, CMD_WR_MEM_ADDR1,
            CMD_WR_MEM_ADDR2, CMD_WR_MEM_ADDR3: begin
              tgt   <= reg_sel(rx_data);
              state <= S_GET_ARG;
            end
            CMD_RD_MEM_ACCESS_COUNT, CMD_RD_MEM_ADDR0, CMD_RD_MEM_ADDR1,
            CMD_RD_MEM_ADDR2, CMD_RD_MEM_ADDR3: begin
              tgt   <= reg_sel(rx_data);
              state <= S_SEND_RSP;
            end
            // Zero-length bursts are silent no-ops.
            CMD_DO_MEM_WRITE: if (count != '0) begin
              ptr   <= addr;
              rem   <= count;
              state <= S_WR_DATA;
            end
            CMD_DO_MEM_READ: if (count != '0) begin
              ptr    <= addr;
              rem    <= count;
              mem_we <= 1'b0;
              state  <= S_RD_MEM;
            end
            default: err <= 1'b1;
          endcase
        end
        // Register write itself happens in u_regs off reg_we.
        S_GET_ARG: if (rx_valid) state <= S_IDLE;
        S_SEND_RSP: begin
          if (rx_valid) err <= 1'b1;
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_data <= rd_byte;
            state   <= S_IDLE;
          end
        end
        S_WR_DATA: if (rx_valid) begin
          mem_wdata <= rx_data;
          mem_we    <= 1'b1;
          state     <= S_WR_MEM;
        end
        S_WR_MEM, S_RD_MEM: begin
          if (rx_valid) err <= 1'b1;
          // Request rises one cycle after entry; a grant is only honoured
          // while the request is actually up.
          if (!mem_req) begin
            mem_req <= 1'b1;
            tmo_cnt <= '0;
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            if (state == S_WR_MEM) begin
              ptr   <= ptr + 1'b1;
              rem   <= rem - 1'b1;
              state <= last ? S_IDLE : S_WR_DATA;
            end else begin
              rdata_q <= mem_rdata;
              state   <= S_RD_SEND;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RD_SEND: begin
          if (rx_valid) err <= 1'b1;
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_data <= rdata_q;
            ptr     <= ptr + 1'b1;
            rem     <= rem - 1'b1;
            state   <= last ? S_IDLE : S_RD_MEM;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_cmd_ctrl.sv
module tb_uart_mem_cmd_ctrl;

  logic        clk, resetn, rx_valid, tx_en, tx_busy, mem_req, mem_we, mem_gnt, busy, err;
  logic [7:0]  rx_data, tx_data, mem_wdata, mem_rdata;
  logic [31:0] mem_addr;

  uart_mem_cmd_ctrl #(.ADDR_W(32), .CNT_W(8), .TIMEOUT(1024)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  typedef struct { logic we; logic [31:0] addr; logic [7:0] data; } txn_t;

  int checks = 0, errors = 0;
  int err_cnt = 0, req_cyc = 0, gnt_wait = 0, tx_left = 0;
  logic tx_hold = 0, gnt_en = 1;
  logic [7:0] got_tx[$];
  txn_t       got_mem[$];
  logic [7:0] env_mem[logic [31:0]];  // memory the DUT talks to
  logic [7:0] ref_mem[logic [31:0]];  // memory contents the model expects

  // Reference model state
  int unsigned m_count = 0;
  logic [31:0] m_addr  = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin #2000000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  function automatic logic [7:0] fill(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  // Monitor: logs transmitted bytes, completed memory handshakes, err pulses.
  initial forever begin
    @(posedge clk);
    if (resetn) begin
      if (tx_en) got_tx.push_back(tx_data);
      if (err) err_cnt++;
      if (mem_req) req_cyc++;
      if (mem_req && mem_gnt) begin
        got_mem.push_back('{mem_we, mem_addr, mem_wdata});
        if (mem_we) env_mem[mem_addr] = mem_wdata;
      end
    end
  end

  // Memory responder: grants after 0..3 cycles.
  initial begin
    mem_gnt = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_gnt) mem_gnt = 0;
      else if (mem_req && gnt_en) begin
        if (gnt_wait == 0) begin
          mem_gnt   = 1;
          mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : fill(mem_addr);
          gnt_wait  = $urandom_range(0, 3);
        end else gnt_wait--;
      end
    end
  end

  // Transmitter: busy 0..4 cycles after each byte, or forced busy.
  initial begin
    tx_busy = 0;
    forever begin
      @(negedge clk);
      if (tx_en) tx_left = $urandom_range(0, 4);
      else if (tx_left != 0) tx_left--;
      tx_busy = tx_hold || (tx_left != 0);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_mem(input int n0);
    int n = 0;
    while (got_mem.size() <= n0 && n < 2000) begin @(negedge clk); n++; end
  endtask

  task automatic pop_tx(input string tag, input logic [7:0] exp);
    int n = 0;
    while (got_tx.size() == 0 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_avail"}, 64'(got_tx.size() != 0), 1);
    if (got_tx.size() != 0) chk(tag, got_tx.pop_front(), exp);
  endtask

  task automatic pop_mem(input string tag, input logic we, input logic [31:0] a, input logic [7:0] d);
    txn_t t;
    chk({tag, "_avail"}, 64'(got_mem.size() != 0), 1);
    if (got_mem.size() != 0) begin
      t = got_mem.pop_front();
      chk(tag, {t.we, t.addr, (we ? t.data : 8'h00)}, {we, a, d});
    end
  endtask

  task automatic wr_reg(input logic [7:0] op, input logic [7:0] v);
    send(op); send(v);
    wait_idle("wr_reg");
    if (op == 8'hA0) m_count = v;
    else m_addr[8*op[1:0] +: 8] = v;
  endtask

  task automatic wr_addr(input logic [31:0] a);
    for (int k = 0; k < 4; k++) wr_reg(8'hB0 + 8'(k), a[8*k +: 8]);
  endtask

  task automatic rd_reg(input string tag, input logic [7:0] op);
    send(op);
    wait_idle(tag);
    pop_tx(tag, (op == 8'hA1) ? 8'(m_count) : m_addr[8*op[1:0] +: 8]);
  endtask

  task automatic burst_wr(input string tag, input logic [7:0] d[$]);
    send(8'hD0);
    foreach (d[i]) begin
      int n0 = got_mem.size();
      send(d[i]);
      wait_mem(n0);
    end
    wait_idle(tag);
    foreach (d[i]) begin
      logic [31:0] a = m_addr + 32'(i);
      ref_mem[a] = d[i];
      pop_mem(tag, 1'b1, a, d[i]);
    end
  endtask

  task automatic burst_rd(input string tag);
    send(8'hD1);
    wait_idle(tag);
    tick(2);
    for (int i = 0; i < int'(m_count); i++) begin
      logic [31:0] a = m_addr + 32'(i);
      pop_mem(tag, 1'b0, a, 8'h00);
      pop_tx(tag, ref_rd(a));
    end
  endtask

  initial begin
    int e0, r0, n;
    logic [7:0] d[$];
    resetn = 0; rx_valid = 0; rx_data = 0;
    tick(3);
    chk("rst_busy", busy, 0);   chk("rst_tx_en", tx_en, 0); chk("rst_tx_data", tx_data, 0);
    chk("rst_req", mem_req, 0); chk("rst_we", mem_we, 0);   chk("rst_addr", mem_addr, 0);
    chk("rst_err", err, 0);
    resetn = 1; tick(2);

    // 1: registers read back zero, no err
    rd_reg("t1_cnt", 8'hA1);
    for (int k = 0; k < 4; k++) rd_reg("t1_addr", 8'hC0 + 8'(k));
    chk("t1_err", err_cnt, 0);

    // 2: register write/read-back
    wr_reg(8'hA0, 8'h34); wr_reg(8'hB0, 8'hAB); wr_reg(8'hB1, 8'hCD);
    wr_reg(8'hB2, 8'hEF); wr_reg(8'hB3, 8'hCD);
    rd_reg("t2_cnt", 8'hA1);
    for (int k = 0; k < 4; k++) rd_reg("t2_addr", 8'hC0 + 8'(k));

    // 3: write then read burst
    wr_reg(8'hA0, 8'h03); wr_addr(32'h10);
    d = '{8'h11, 8'h22, 8'h33};
    burst_wr("t3_wr", d);
    burst_rd("t3_rd");
    rd_reg("t3_cnt", 8'hA1); rd_reg("t3_a0", 8'hC0);

    // 4: address wrap and zero-length burst
    wr_addr(32'hFFFF_FFFF); wr_reg(8'hA0, 8'h02);
    burst_rd("t4_wrap");
    wr_reg(8'hA0, 8'h00);
    r0 = req_cyc; send(8'hD1); tick(5);
    chk("t4_zero_busy", busy, 0); chk("t4_zero_req", req_cyc - r0, 0);

    // 5: bad opcode, stray byte in RD_SEND
    e0 = err_cnt; send(8'h55); tick(3);
    chk("t5_bad_err", err_cnt - e0, 1); chk("t5_bad_tx", got_tx.size(), 0);
    wr_reg(8'hA0, 8'h01); wr_addr(32'h10);
    tx_hold = 1; tick(1);
    n = got_mem.size(); send(8'hD1); wait_mem(n);
    e0 = err_cnt; send(8'h77); tick(2);
    chk("t5_stray_err", err_cnt - e0, 1); chk("t5_stray_busy", busy, 1);
    tx_hold = 0;
    wait_idle("t5_stray"); tick(2);
    pop_mem("t5_stray_rd", 1'b0, 32'h10, 8'h00);
    pop_tx("t5_stray_tx", ref_rd(32'h10));

    // Randomized bursts, one straddling the address wrap
    e0 = err_cnt;
    for (int it = 0; it < 4; it++) begin
      logic [7:0] c = 8'($urandom_range(1, 5));
      wr_reg(8'hA0, c);
      wr_addr(it == 0 ? 32'hFFFF_FFFE : $urandom);
      d = {};
      for (int i = 0; i < int'(c); i++) d.push_back(8'($urandom));
      burst_wr("rnd_wr", d);
      burst_rd("rnd_rd");
      rd_reg("rnd_cnt", 8'hA1); rd_reg("rnd_a3", 8'hC3);
    end
    chk("rnd_err", err_cnt - e0, 0);

    // 6: grant timeout, then reset mid write burst
    wr_reg(8'hA0, 8'h02);
    gnt_en = 0; e0 = err_cnt; r0 = req_cyc;
    send(8'hD1); wait_idle("t6_tmo"); tick(2);
    chk("t6_tmo_req_cycles", req_cyc - r0, 1024);
    chk("t6_tmo_err", err_cnt - e0, 1);
    chk("t6_tmo_busy", busy, 0); chk("t6_tmo_nomem", got_mem.size(), 0);
    send(8'hD0); send(8'h99);
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    chk("t6_rst_req_up", mem_req, 1);
    resetn = 0; tick(1);
    chk("t6_rst_req", mem_req, 0); chk("t6_rst_busy", busy, 0); chk("t6_rst_tx", tx_en, 0);
    resetn = 1; gnt_en = 1; m_count = 0; m_addr = 0; tick(2);
    rd_reg("t6_cnt", 8'hA1); rd_reg("t6_a0", 8'hC0);

    tick(5);
    chk("end_tx_empty", got_tx.size(), 0); chk("end_mem_empty", got_mem.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
